// File: rtl/ysyx_22050710_ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states, fault causes,
// the NOP encoding and the default reset PC.
package ysyx_22050710_ifu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_AR     = 3'd1,
        ST_R      = 3'd2,
        ST_OUT    = 3'd3,
        ST_WAITPC = 3'd4
    } ifu_state_t;

    localparam logic [1:0]  CAUSE_NONE       = 2'b00;
    localparam logic [1:0]  CAUSE_MISALIGN   = 2'b01;
    localparam logic [1:0]  CAUSE_ACCESS     = 2'b10;
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h8000_0000;

    // Pick the 32-bit half of an 8-byte beat addressed by pc[2].
    function automatic logic [31:0] pick_word(input logic [63:0] beat, input logic upper);
        return upper ? beat[63:32] : beat[31:0];
    endfunction

endpackage

// File: rtl/ysyx_22050710_ifu_if.sv
// Fetch-side bus of the IFU: memory read address/data channels plus the
// decode and execute handshakes. Every valid/ready pair transfers on a rising
// clock edge where both are high; a valid, once raised, holds with stable
// payload until the matching ready is seen.
interface ysyx_22050710_ifu_if;

    logic [63:0] o_araddr;
    logic        o_arvalid;
    logic        i_arready;
    logic [63:0] i_rdata;
    logic [1:0]  i_rresp;
    logic        i_rvalid;
    logic        o_rready;
    logic [63:0] o_pc;
    logic [31:0] o_inst;
    logic        o_valid;
    logic        i_ready;
    logic [63:0] i_nextpc;
    logic        i_nextpc_valid;
    logic        o_fault;
    logic [1:0]  o_fault_cause;

    modport master (
        output o_araddr, o_arvalid, o_rready, o_pc, o_inst, o_valid, o_fault, o_fault_cause,
        input  i_arready, i_rdata, i_rresp, i_rvalid, i_ready, i_nextpc, i_nextpc_valid
    );

    modport slave (
        input  o_araddr, o_arvalid, o_rready, o_pc, o_inst, o_valid, o_fault, o_fault_cause,
        output i_arready, i_rdata, i_rresp, i_rvalid, i_ready, i_nextpc, i_nextpc_valid
    );

endinterface

// File: rtl/ysyx_22050710_ifu.sv
// Single-outstanding instruction fetch unit: issues one aligned 8-byte read per
// PC, presents the selected 32-bit word to decode, then waits for the next PC.
module ysyx_22050710_ifu
    import ysyx_22050710_ifu_pkg::*;
#(
    parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    ysyx_22050710_ifu_if.master  bus,
    output ifu_state_t           dbg_state
);

    ifu_state_t  state, state_next;
    logic [63:0] pc, pc_next;
    logic [31:0] inst, inst_next;
    logic        fault, fault_next;
    logic [1:0]  cause, cause_next;
    logic        arvalid, rready, valid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
            pc    <= RESET_PC;
            inst  <= '0;
            fault <= 1'b0;
            cause <= CAUSE_NONE;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            inst  <= inst_next;
            fault <= fault_next;
            cause <= cause_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        inst_next  = inst;
        fault_next = fault;
        cause_next = cause;
        arvalid    = 1'b0;
        rready     = 1'b0;
        valid      = 1'b0;
        case (state)
            ST_IDLE: state_next = ST_AR;
            ST_AR: begin
                // A misaligned PC never reaches memory; it is reported as a fault.
                if (pc[1:0] != 2'b00) begin
                    inst_next  = INST_NOP;
                    fault_next = 1'b1;
                    cause_next = CAUSE_MISALIGN;
                    state_next = ST_OUT;
                end else begin
                    arvalid = 1'b1;
                    if (bus.i_arready) state_next = ST_R;
                end
            end
            ST_R: begin
                rready = 1'b1;
                if (bus.i_rvalid) begin
                    if (bus.i_rresp != 2'b00) begin
                        inst_next  = INST_NOP;
                        fault_next = 1'b1;
                        cause_next = CAUSE_ACCESS;
                    end else begin
                        inst_next = pick_word(bus.i_rdata, pc[2]);
                    end
                    state_next = ST_OUT;
                end
            end
            ST_OUT: begin
                valid = 1'b1;
                if (bus.i_ready) state_next = ST_WAITPC;
            end
            ST_WAITPC: begin
                if (bus.i_nextpc_valid) begin
                    pc_next    = bus.i_nextpc;
                    fault_next = 1'b0;
                    cause_next = CAUSE_NONE;
                    state_next = ST_AR;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.o_araddr      = {pc[63:3], 3'b000};
    assign bus.o_arvalid     = arvalid;
    assign bus.o_rready      = rready;
    assign bus.o_pc          = pc;
    assign bus.o_inst        = inst;
    assign bus.o_valid       = valid;
    assign bus.o_fault       = fault;
    assign bus.o_fault_cause = cause;
    assign dbg_state         = state;

endmodule
